ft245_tx: RTL
=============

FT245_TX -- requirements
Module: ft245_tx

Interface
REQ-001 Parameter TX_WIDTH, default 8: width of the upstream byte bus and of the FT245 data bus.
REQ-002 Parameter SETUP_CYCLES, default 1: cycles data is driven with ftdi_wr low before the strobe; legal range >=1.
REQ-003 Parameter WR_PULSE_CYCLES, default 3: cycles ftdi_wr is held high; legal range >=1.
REQ-004 Parameter GAP_CYCLES, default 2: cycles after the strobe before a new byte may be accepted; legal range >=1.
REQ-005 clk  input  1  single system clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low; asserting it forces the reset state immediately, and state is released on the first clk edge after deassertion.
REQ-007 tx_data  input  TX_WIDTH  byte offered by the upstream tx multiplexer.
REQ-008 tx_rdy  input  1  tx_data is valid.
REQ-009 tx_ack  output  1  byte accepted this cycle; upstream advances on the same edge.
REQ-010 ftdi_txe_n  input  1  FT245 TXE#, asynchronous; low means the FT245 FIFO has room.
REQ-011 ftdi_wr  output  1  FT245 WR strobe; the FT245 latches the byte on its falling edge.
REQ-012 ftdi_d_out  output  TX_WIDTH  data driven toward the FT245 bus.
REQ-013 ftdi_d_oe  output  1  output enable for the bidirectional FT245 data pads.
REQ-014 byte_count  output  16  count of bytes strobed into the FT245 since reset, wrapping modulo 2^16.

Function
REQ-015 ftdi_txe_n shall pass through a 2-flop synchronizer whose flops reset to 1; txe_ok is the inverted synchronizer output, and only txe_ok is used internally.
REQ-016 The state machine shall have exactly four states: IDLE, SETUP, STROBE and GAP.
REQ-017 tx_ack shall be combinational: asserted exactly when the state is IDLE, tx_rdy=1 and txe_ok=1, and 0 at all other times.
REQ-018 On a clock edge with tx_ack=1, tx_data shall be loaded into the ftdi_d_out register and the state shall go from IDLE to SETUP; otherwise IDLE is held.
REQ-019 SETUP shall last SETUP_CYCLES cycles with ftdi_wr=0, then go to STROBE.
REQ-020 STROBE shall last WR_PULSE_CYCLES cycles with ftdi_wr=1 (registered output), then go to GAP; ftdi_wr shall fall on the edge that enters GAP.
REQ-021 byte_count shall increment by 1 on the edge leaving STROBE; 0xFFFF shall wrap to 0x0000.
REQ-022 GAP shall last GAP_CYCLES cycles with ftdi_wr=0, then return to IDLE; txe_ok is not sampled during SETUP, STROBE or GAP.
REQ-023 ftdi_d_out shall stay stable from the load edge until the state leaves GAP.
REQ-024 ftdi_d_oe shall be 1 in SETUP, STROBE and GAP, and 0 in IDLE.
REQ-025 Per-byte throughput shall be 1+SETUP_CYCLES+WR_PULSE_CYCLES+GAP_CYCLES cycles: 7 cycles with default parameters when tx_rdy and txe_ok stay high.
REQ-026 When txe_ok falls, no new byte shall be accepted; a byte already loaded shall complete its strobe.
REQ-027 A tx_rdy that deasserts in IDLE without an ack shall leave state and outputs unchanged, and no data shall be captured.
REQ-028 A single internal cycle counter, sized for max(SETUP_CYCLES, WR_PULSE_CYCLES, GAP_CYCLES), shall time all three timed states and reload on every state change.

Reset
REQ-029 While rst=0, the block shall hold: state=IDLE, ftdi_wr=0, ftdi_d_oe=0, ftdi_d_out=0, byte_count=0, synchronizer flops=1, cycle counter=0, and therefore tx_ack=0.
REQ-030 Reset asserted mid-STROBE shall drop ftdi_wr immediately (asynchronously); the truncated byte is lost and is not counted.
REQ-031 After reset deassertion, no byte shall be accepted until txe_ok=1, i.e. at least 2 edges after ftdi_txe_n is low.

Verification
REQ-032 Defaults, ftdi_txe_n=0, tx_rdy=1 with 0xA5 -> tx_ack pulses once; ftdi_d_out=0xA5 with oe=1; ftdi_wr high 3 cycles starting 2 cycles after ack; byte_count=1.
REQ-033 Stream 0x01..0x04 with tx_rdy held high -> acks exactly 7 cycles apart; FT245 model latches 0x01, 0x02, 0x03, 0x04 in order; byte_count=4.
REQ-034 ftdi_txe_n=1, tx_rdy=1 for 20 cycles, then ftdi_txe_n=0 -> no ack while high; first ack on the 3rd edge after the fall.
REQ-035 ftdi_txe_n rises during STROBE -> current byte completes and is counted; no further ack until ftdi_txe_n returns low.
REQ-036 byte_count preset to 0xFFFF by sending 65535 bytes, one more byte sent -> byte_count=0x0000.
REQ-037 rst=0 asserted in the 2nd STROBE cycle -> ftdi_wr, ftdi_d_oe and tx_ack drop to 0 with no clock edge; byte_count=0; after release the next byte behaves as in REQ-032.

Source files
------------

// File: rtl/ft245_tx.sv
// rtl/ft245_tx.sv - FT245 asynchronous FIFO write-side byte transmitter
module ft245_tx #(
  parameter int TX_WIDTH        = 8,
  parameter int SETUP_CYCLES    = 1,
  parameter int WR_PULSE_CYCLES = 3,
  parameter int GAP_CYCLES      = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [TX_WIDTH-1:0] tx_data,
  input  logic                tx_rdy,
  output logic                tx_ack,
  input  logic                ftdi_txe_n,
  output logic                ftdi_wr,
  output logic [TX_WIDTH-1:0] ftdi_d_out,
  output logic                ftdi_d_oe,
  output logic [15:0]         byte_count
);

  // One down-counter times every timed state, so it must hold the longest
  // of the three durations minus one.
  localparam int MAX_SW     = (SETUP_CYCLES > WR_PULSE_CYCLES) ? SETUP_CYCLES : WR_PULSE_CYCLES;
  localparam int MAX_CYCLES = (MAX_SW > GAP_CYCLES) ? MAX_SW : GAP_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(WR_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    GAP    = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               txe_meta;
  logic               txe_sync;
  logic               txe_ok;
  logic               load;
  logic               count_inc;
  logic               wr_nxt;
  logic [15:0]        count_q;

  // TXE# is asynchronous to clk; two flops resolve metastability and
  // reset to "FIFO full" so nothing is written straight out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      txe_meta <= 1'b1;
      txe_sync <= 1'b1;
    end else begin
      txe_meta <= ftdi_txe_n;
      txe_sync <= txe_meta;
    end
  end

  assign txe_ok = ~txe_sync;

  // State, timer, strobe, data and byte counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      ftdi_wr    <= 1'b0;
      ftdi_d_out <= '0;
      count_q    <= 16'h0000;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      ftdi_wr <= wr_nxt;
      if (load) begin
        ftdi_d_out <= tx_data;
      end
      if (count_inc) begin
        count_q <= count_q + 16'h0001;
      end
    end
  end

  // Next-state, timer reload and handshake decode.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    tx_ack    = 1'b0;
    load      = 1'b0;
    count_inc = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (tx_rdy && txe_ok) begin
          tx_ack    = 1'b1;
          load      = 1'b1;
          state_nxt = SETUP;
          cnt_nxt   = SETUP_LOAD;
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_nxt = STROBE;
          cnt_nxt   = PULSE_LOAD;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      STROBE: begin
        if (cnt == '0) begin
          // The falling WR edge is where the FT245 takes the byte, so the
          // count advances on the same edge.
          state_nxt = GAP;
          cnt_nxt   = GAP_LOAD;
          count_inc = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      GAP: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
    // WR is registered from the next state so it is glitch-free at the pad.
    wr_nxt = (state_nxt == STROBE);
  end

  assign ftdi_d_oe  = (state != IDLE);
  assign byte_count = count_q;

endmodule
